// File: rtl/ex_stage_elastic_buf.sv
// ex_stage_elastic_buf
//   Elastic FIFO between the ID/EX boundary and the EX stage. Holds DEPTH
//   packed stage payloads with valid/ready handshakes on both sides. It
//   reports its occupancy and drops every entry on a branch redirect (flush).
//
//   Ports
//     clk, rst             clock; asynchronous active-high reset
//     flush                redirect: drop all entries and discard same-cycle input
//     in_valid/in_ready    upstream handshake; in_data is the payload
//     out_valid/out_ready  downstream handshake; out_data is the head payload
//     count                number of stored entries, 0..DEPTH
//
//   Optional feature macro: EX_STAGE_ELASTIC_BUF_BYPASS_EN
//     When it is defined and the buffer is empty, an incoming payload is
//     presented on out_* in the same cycle. If EX takes it, it is never
//     stored.
module ex_stage_elastic_buf #(
  parameter  int DATA_W = 256,
  parameter  int DEPTH  = 2,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              empty, full, push, pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  // Depends on registered state only, so upstream never sees out_ready.
  assign in_ready = ~full;
  assign count    = count_q;

`ifdef EX_STAGE_ELASTIC_BUF_BYPASS_EN
  logic bypass;
  assign bypass    = empty & in_valid & ~flush;
  assign out_valid = (~empty & ~flush) | bypass;
  assign out_data  = bypass ? in_data : mem_q[rd_ptr_q];
  // A bypassed payload that EX takes right away never touches storage.
  assign push      = in_valid & ~full & ~flush & ~(bypass & out_ready);
  assign pop       = ~empty & out_ready & ~flush;
`else
  assign out_valid = ~empty & ~flush;
  assign out_data  = mem_q[rd_ptr_q];
  assign push      = in_valid & ~full & ~flush;
  assign pop       = out_valid & out_ready;
`endif

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // Empty the buffer by moving the read pointer onto the write pointer.
      // The stored data is not touched.
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap through natural overflow.
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is not reset. Writes are blocked while rst is high,
  // so no transfer happens on an edge seen during reset.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= in_data;
  end

endmodule
